// File: rtl/adc_in_ts_capture.sv
// rtl/adc_in_ts_capture.sv - ADC-input timestamp capture: free-running counter latched on a qualified trigger.
// Optional PPS counter re-sync enabled by defining ADC_TS_PPS_SYNC_EN.
module adc_in_ts_capture #(
  parameter int CNT_W       = 48,
  parameter int TS_SHIFT    = 0,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        arm,
  input  logic        auto_rearm,
  input  logic        clear,
  input  logic        trig,
`ifdef ADC_TS_PPS_SYNC_EN
  input  logic        pps,
`endif
  output logic [31:0] ts_out,
  output logic        ts_valid,
  output logic [7:0]  cap_count,
  output logic        ts_missed,
  output logic        armed
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  // Holdoff counter runs HOLD_LOAD..0, so HOLDOFF lasts exactly HOLDOFF_CYC cycles.
  localparam logic [15:0] HOLD_LOAD = 16'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

  logic [CNT_W-1:0] r_ts_cnt;
  logic             r_arm_d;
  logic [1:0]       r_state;
  logic [15:0]      r_hold_cnt;
  logic [31:0]      r_ts_out;
  logic             r_ts_valid;
  logic [7:0]       r_cap_count;
  logic             r_ts_missed;
  logic             r_armed;

  logic             w_arm_rise;
  logic [1:0]       w_rearm_state;
  logic [1:0]       w_next_state;
  logic [15:0]      w_next_hold;
  logic             w_capture;
  logic             w_missed_set;

  assign w_arm_rise    = arm & ~r_arm_d;
  assign w_rearm_state = auto_rearm ? S_ARMED : S_IDLE;

  always_comb begin
    w_next_state = r_state;
    w_next_hold  = r_hold_cnt;
    w_capture    = 1'b0;
    w_missed_set = 1'b0;
    if (clear) begin
      w_next_state = S_IDLE;
      w_next_hold  = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arm_rise) w_next_state = S_ARMED;
        end
        S_ARMED: begin
          if (trig) begin
            w_capture = 1'b1;
            if (HOLDOFF_CYC == 0) begin
              w_next_state = w_rearm_state;
            end else begin
              w_next_state = S_HOLDOFF;
              w_next_hold  = HOLD_LOAD;
            end
          end
        end
        S_HOLDOFF: begin
          if (trig) w_missed_set = 1'b1;
          if (r_hold_cnt == 16'd0) begin
            w_next_state = w_rearm_state;
          end else begin
            w_next_hold = r_hold_cnt - 16'd1;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef ADC_TS_PPS_SYNC_EN
  logic r_pps_d;

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_pps_d  <= 1'b0;
      r_ts_cnt <= '0;
    end else begin
      r_pps_d <= pps;
      if (pps & ~r_pps_d) r_ts_cnt <= '0;
      else                r_ts_cnt <= r_ts_cnt + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) r_ts_cnt <= '0;
    else          r_ts_cnt <= r_ts_cnt + CNT_W'(1);
  end
`endif

  // armed is registered from the next state so it tracks the state register exactly.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_arm_d     <= 1'b0;
      r_state     <= S_IDLE;
      r_hold_cnt  <= 16'd0;
      r_ts_out    <= 32'd0;
      r_ts_valid  <= 1'b0;
      r_cap_count <= 8'd0;
      r_ts_missed <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_arm_d    <= arm;
      r_state    <= w_next_state;
      r_hold_cnt <= w_next_hold;
      r_armed    <= (w_next_state == S_ARMED);
      if (w_capture) r_ts_out <= r_ts_cnt[TS_SHIFT +: 32];
      if (clear) begin
        r_ts_valid  <= 1'b0;
        r_cap_count <= 8'd0;
        r_ts_missed <= 1'b0;
      end else begin
        if (w_capture) begin
          r_ts_valid  <= 1'b1;
          r_cap_count <= r_cap_count + 8'd1;
        end
        if (w_missed_set) r_ts_missed <= 1'b1;
      end
    end
  end

  assign ts_out    = r_ts_out;
  assign ts_valid  = r_ts_valid;
  assign cap_count = r_cap_count;
  assign ts_missed = r_ts_missed;
  assign armed     = r_armed;

endmodule

// File: tb/tb_adc_in_ts_capture.sv
// tb/tb_adc_in_ts_capture.sv - directed-vector bench for adc_in_ts_capture.
module tb_adc_in_ts_capture;

  logic user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  logic user_rst = 1'b1;
  logic arm = 1'b0, auto_rearm = 1'b0, clear = 1'b0, trig = 1'b0, pps = 1'b0;
  logic arm_w = 1'b0, trig_w = 1'b0, clear_w = 1'b0, rearm_w = 1'b1, pps_w = 1'b0;

  logic [31:0] ts_out, ts_out_w;
  logic        ts_valid, ts_missed, armed, ts_valid_w, ts_missed_w, armed_w;
  logic [7:0]  cap_count, cap_count_w;

  adc_in_ts_capture dut (
    .user_clk(user_clk), .user_rst(user_rst), .arm(arm), .auto_rearm(auto_rearm),
    .clear(clear), .trig(trig),
`ifdef ADC_TS_PPS_SYNC_EN
    .pps(pps),
`endif
    .ts_out(ts_out), .ts_valid(ts_valid), .cap_count(cap_count),
    .ts_missed(ts_missed), .armed(armed)
  );

  adc_in_ts_capture #(.CNT_W(40), .TS_SHIFT(8), .HOLDOFF_CYC(0)) dut_w (
    .user_clk(user_clk), .user_rst(user_rst), .arm(arm_w), .auto_rearm(rearm_w),
    .clear(clear_w), .trig(trig_w),
`ifdef ADC_TS_PPS_SYNC_EN
    .pps(pps_w),
`endif
    .ts_out(ts_out_w), .ts_valid(ts_valid_w), .cap_count(cap_count_w),
    .ts_missed(ts_missed_w), .armed(armed_w)
  );

  // Reference cycle count: equals the DUT counter value between posedges.
  int unsigned cyc;
  always @(posedge user_clk or posedge user_rst) begin
    if (user_rst) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    int guard = 0;
    while (cyc != c && guard < 5000) begin
      @(negedge user_clk);
      guard++;
    end
    if (cyc != c) chk("wait_cyc_timeout", cyc, c);
  endtask

  initial begin
    repeat (2) @(negedge user_clk);
    chk("rst_ts_out",    ts_out, 32'd0);
    chk("rst_ts_valid",  32'(ts_valid), 32'd0);
    chk("rst_cap_count", 32'(cap_count), 32'd0);
    chk("rst_ts_missed", 32'(ts_missed), 32'd0);
    chk("rst_armed",     32'(armed), 32'd0);
    user_rst = 1'b0;

    for (int i = 0; i < 200 && cyc < 100; i++) begin
      @(negedge user_clk);
      trig = (cyc % 7 == 3);
    end
    trig = 1'b0;
    @(negedge user_clk);
    chk("idle_ts_valid",  32'(ts_valid), 32'd0);
    chk("idle_cap_count", 32'(cap_count), 32'd0);
    chk("idle_armed",     32'(armed), 32'd0);
    chk("idle_ts_out",    ts_out, 32'd0);

    user_rst = 1'b1;
    @(negedge user_clk);
    user_rst = 1'b0;
    auto_rearm = 1'b1;

    wait_cyc(5);   arm_w = 1'b1;
    wait_cyc(10);  arm = 1'b1;
    chk("armed_before_edge", 32'(armed), 32'd0);
    wait_cyc(11);  chk("armed_after_edge", 32'(armed), 32'd1);
    wait_cyc(50);  trig = 1'b1;
    wait_cyc(51);  trig = 1'b0;
    chk("cap1_ts_out",    ts_out, 32'd50);
    chk("cap1_ts_valid",  32'(ts_valid), 32'd1);
    chk("cap1_cap_count", 32'(cap_count), 32'd1);
    chk("cap1_armed",     32'(armed), 32'd0);
    wait_cyc(56);  trig = 1'b1;
    wait_cyc(57);  trig = 1'b0;
    chk("hold_missed",    32'(ts_missed), 32'd1);
    chk("hold_ts_out",    ts_out, 32'd50);
    chk("hold_cap_count", 32'(cap_count), 32'd1);
    wait_cyc(66);  chk("hold_armed_66", 32'(armed), 32'd0);
    wait_cyc(67);  chk("rearm_armed_67", 32'(armed), 32'd1);
    wait_cyc(70);  trig = 1'b1;
    wait_cyc(71);  trig = 1'b0;
    chk("cap2_ts_out",    ts_out, 32'd70);
    chk("cap2_cap_count", 32'(cap_count), 32'd2);
    wait_cyc(72);  auto_rearm = 1'b0;
    wait_cyc(88);  chk("noarm_armed", 32'(armed), 32'd0);
    wait_cyc(90);  trig = 1'b1;
    wait_cyc(91);  trig = 1'b0;
    chk("idle_trig_count", 32'(cap_count), 32'd2);
    chk("idle_trig_ts",    ts_out, 32'd70);
    wait_cyc(92);  arm = 1'b0;
    wait_cyc(93);  arm = 1'b1;
    wait_cyc(94);  chk("rearm_manual", 32'(armed), 32'd1);
    auto_rearm = 1'b1;

    wait_cyc(100); trig = 1'b1; clear = 1'b1;
    wait_cyc(101); trig = 1'b0; clear = 1'b0;
    chk("clr_cap_count", 32'(cap_count), 32'd0);
    chk("clr_ts_valid",  32'(ts_valid), 32'd0);
    chk("clr_ts_missed", 32'(ts_missed), 32'd0);
    chk("clr_armed",     32'(armed), 32'd0);
    chk("clr_ts_out",    ts_out, 32'd70);
    arm = 1'b0;
    wait_cyc(103); arm = 1'b1; clear = 1'b1;
    wait_cyc(104); clear = 1'b0;
    chk("clr_arm_armed", 32'(armed), 32'd0);
    wait_cyc(106); chk("arm_edge_consumed", 32'(armed), 32'd0);

    wait_cyc(110);
    force dut_w.r_ts_cnt = 40'hFF_FFFF_FF00;
    #1;
    release dut_w.r_ts_cnt;
    wait_cyc(111); trig_w = 1'b1;
    wait_cyc(112); trig_w = 1'b0;
    chk("wide_pre_wrap",  ts_out_w, 32'hFFFF_FFFF);
    chk("wide_armed",     32'(armed_w), 32'd1);
    wait_cyc(367); trig_w = 1'b1;
    wait_cyc(368); trig_w = 1'b0;
    chk("wide_post_wrap", ts_out_w, 32'h0000_0000);
    chk("wide_count",     32'(cap_count_w), 32'd2);

    wait_cyc(990);  arm = 1'b0;
    wait_cyc(991);  arm = 1'b1;
    wait_cyc(993);  chk("pps_armed", 32'(armed), 32'd1);
`ifdef ADC_TS_PPS_SYNC_EN
    wait_cyc(1000); pps = 1'b1;
`endif
    wait_cyc(1003); trig = 1'b1;
    wait_cyc(1004); trig = 1'b0; pps = 1'b0;
`ifdef ADC_TS_PPS_SYNC_EN
    chk("pps_ts_out", ts_out, 32'd2);
`else
    chk("free_ts_out", ts_out, 32'd1003);
`endif

    wait_cyc(1005);
    user_rst = 1'b1;
    #1;
    chk("async_rst_ts_out", ts_out, 32'd0);
    chk("async_rst_count",  32'(cap_count), 32'd0);
    chk("async_rst_armed",  32'(armed), 32'd0);
    chk("async_rst_wide",   ts_out_w, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
